// File: rtl/mux_scan_nx1_pkg.sv
// Shared types and constants for the scanning N-to-1 channel multiplexer.
package mux_scan_pkg;

    // Output-stage state: no beat, beat presented, beat stalled by the consumer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

endpackage

// File: rtl/mux_scan_nx1_rr_next_ch.sv
// Wrap-around next-set-bit finder: first set bit of mask strictly after ptr,
// searching upward and wrapping; ptr itself is the last position examined.
module rr_next_ch #(
    parameter  int N_CH  = 16,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_CH-1:0]  mask,
    output logic [SEL_W-1:0] nxt,
    output logic             found,
    output logic             wrapped
);

    // Walk offsets 1..N_CH from ptr; the first hit wins. wrapped flags a hit at or below ptr.
    always_comb begin
        int idx;
        logic [SEL_W-1:0] idx_s;
        nxt     = '0;
        found   = 1'b0;
        wrapped = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_s = SEL_W'(idx);
            if (!found && mask[idx_s]) begin
                nxt     = idx_s;
                found   = 1'b1;
                wrapped = (idx <= int'(ptr));
            end
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel multiplexer with fixed-select and round-robin scan
// modes and a valid/ready output stage that never drops an accepted beat.
//
// state   | meaning
// IDLE    | no beat on the output; every cycle is a load opportunity
// RUN     | beat presented; consumer may take it this cycle
// HOLD    | beat presented but stalled; outputs frozen, inputs ignored
module mux_scan_nx1
    import mux_scan_pkg::*;
#(
    parameter  int N_CH   = 16,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic [SEL_W-1:0]       sel_in_i,
    input  logic [N_CH-1:0]        ch_en_i,
    input  logic [N_CH*DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [SEL_W-1:0]       out_ch_o,
    output logic                   out_wrap_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   sel_err_o
);

    localparam int MASK_EXT_W = 2 ** SEL_W;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_ch_q, out_ch_d;
    logic                  out_wrap_q, out_wrap_d;
    logic                  sel_err_q, sel_err_d;
    logic [SEL_W-1:0]      last_ch_q, last_ch_d;

    logic [DATA_W-1:0]     ch_data [N_CH];
    logic [MASK_EXT_W-1:0] mask_ext;
    logic [SEL_W-1:0]      rr_nxt;
    logic                  rr_found;
    logic                  rr_wrapped;
    logic [SEL_W-1:0]      cand;
    logic                  cand_good;
    logic                  load;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign ch_data[g] = data_in_i[g*DATA_W +: DATA_W];
    end

    rr_next_ch #(.N_CH(N_CH)) u_rr_next_ch (
        .ptr     (last_ch_q),
        .mask    (ch_en_i),
        .nxt     (rr_nxt),
        .found   (rr_found),
        .wrapped (rr_wrapped)
    );

    // Mask padded to the full select range so out-of-range fixed selects read as disabled.
    always_comb begin
        mask_ext             = '0;
        mask_ext[N_CH-1:0]   = ch_en_i;
    end

    // Candidate channel for the next load, from either the fixed select or the scan pointer.
    always_comb begin
        cand      = '0;
        cand_good = 1'b0;
        if (mode_i == MODE_SCAN) begin
            cand      = rr_nxt;
            cand_good = rr_found;
        end else begin
            cand      = sel_in_i;
            cand_good = mask_ext[sel_in_i];
        end
    end

    // Next-state and output-register logic; nothing moves unless the output slot is free.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_wrap_d = out_wrap_q;
        last_ch_d  = last_ch_q;
        sel_err_d  = 1'b0;
        load       = (state_q == ST_IDLE) || out_ready_i;
        if (load) begin
            if (en_i && cand_good) begin
                state_d    = ST_RUN;
                out_data_d = ch_data[cand];
                out_ch_d   = cand;
                if (mode_i == MODE_SCAN) begin
                    out_wrap_d = rr_wrapped;
                    last_ch_d  = cand;
                end else begin
                    out_wrap_d = 1'b0;
                end
            end else begin
                state_d    = ST_IDLE;
                out_wrap_d = 1'b0;
            end
            sel_err_d = en_i && (mode_i == MODE_FIXED) && !cand_good;
        end else begin
            state_d = ST_HOLD;
        end
    end

    // State and output registers; reset points the scan pointer at the top channel so channel 0 comes first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_wrap_q <= 1'b0;
            sel_err_q  <= 1'b0;
            last_ch_q  <= SEL_W'(N_CH - 1);
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_wrap_q <= out_wrap_d;
            sel_err_q  <= sel_err_d;
            last_ch_q  <= last_ch_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_wrap_o  = out_wrap_q;
    assign out_valid_o = (state_q != ST_IDLE);
    assign sel_err_o   = sel_err_q;

endmodule
